// File: rtl/multicycle_control_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_control_pkg
//   Shared constants for the MIPS multicycle control path: opcodes, ALUop
//   codes, PC-source and ALU-B select codes, and the control FSM state codes.
//   Also used by alu_control and the datapath so all agree on encodings.
// -----------------------------------------------------------------------------
package multicycle_control_pkg;

    // IR[31:26] opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALUop codes consumed by alu_control
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;
    localparam logic [1:0] ALUOP_OR   = 2'b11;

    // PC source mux
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REGA   = 2'b11;

    // ALU B operand mux
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Control FSM states; codes 13..15 are unused
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_IMM_EXEC  = 4'd10,
        S_IMM_WB    = 4'd11,
        S_JUMP      = 4'd12
    } state_e;

endpackage

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Main control FSM for the 32-bit MIPS multicycle datapath. Sequences each
//   instruction through fetch/decode/execute/memory/writeback and drives all
//   datapath enables. Outputs are Moore decodes of the state, except pc_write
//   and ir_write which are qualified combinationally by mem_ready, zero, jr.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   opcode          : IR[31:26], stable from DECODE until next FETCH completes
//   zero            : ALU zero flag (branch resolution)
//   jr              : from alu_control, meaningful while alu_op = FUNC
//   mem_ready       : memory access complete (stalls FETCH/MEM_READ/MEM_WRITE)
//   pc_write, pc_source, iord, mem_read, mem_write, ir_write, mem_to_reg,
//   reg_dst, reg_write, alu_src_a, alu_src_b, ext_zero, alu_op : datapath ctl
//   illegal_op      : one-cycle pulse in DECODE for an unsupported opcode
//   state           : current state code, for debug
// -----------------------------------------------------------------------------
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       jr,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic [1:0] alu_op,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        // Everything defaults low; unused codes 13..15 fall back to FETCH.
        state_d    = S_FETCH;
        pc_write   = 1'b0;
        pc_source  = PCSRC_ALU;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        ext_zero   = 1'b0;
        alu_op     = ALUOP_ADD;
        illegal_op = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                // PC+4 computed every cycle, but only committed with the IR
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end

            S_DECODE: begin
                // Speculatively compute branch target into ALUOut
                alu_src_b = SRCB_IMM_SH;
                case (opcode)
                    OP_LW, OP_SW:    state_d = S_MEM_ADDR;
                    OP_RTYPE:        state_d = S_R_EXEC;
                    OP_BEQ, OP_BNE:  state_d = S_BRANCH;
                    OP_ADDI, OP_ORI: state_d = S_IMM_EXEC;
                    OP_J:            state_d = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end

            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end

            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = mem_ready ? S_MEM_WB : S_MEM_READ;
            end

            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end

            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                state_d   = mem_ready ? S_FETCH : S_MEM_WRITE;
            end

            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNC;
                // jr resolves here: load PC from register A, skip writeback
                if (jr) begin
                    pc_write  = 1'b1;
                    pc_source = PCSRC_REGA;
                    state_d   = S_FETCH;
                end else begin
                    state_d   = S_R_WB;
                end
            end

            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end

            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_source = PCSRC_ALUOUT;
                // beq taken on zero, bne taken on !zero
                pc_write  = zero ^ (opcode == OP_BNE);
                state_d   = S_FETCH;
            end

            S_IMM_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                if (opcode == OP_ORI) begin
                    alu_op   = ALUOP_OR;
                    ext_zero = 1'b1;
                end
                state_d = S_IMM_WB;
            end

            S_IMM_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end

            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                state_d   = S_FETCH;
            end

            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//   Instruction-level reference model: each instruction is expanded into its
//   expected per-cycle control vector sequence. The driver pushes the expected
//   vector for each cycle into a queue; a monitor pops and compares on the
//   falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_write;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [1:0] alu_op;
        logic       illegal_op;
    } out_t;

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                           BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000,
                           ORI = 6'b001101, JMP = 6'b000010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero, jr, mem_ready;
    logic       pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg;
    logic       reg_dst, reg_write, alu_src_a, ext_zero, illegal_op;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic [3:0] state;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .jr(jr),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_source(pc_source),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .ext_zero(ext_zero), .alu_op(alu_op), .illegal_op(illegal_op),
        .state(state)
    );

    always #5 clk = ~clk;

    out_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc_no     = 0;

    // Monitor: one expected vector per cycle, compared mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            out_t e, a;
            e = exp_q.pop_front();
            a = '{state, pc_write, pc_source, iord, mem_read, mem_write,
                  ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                  alu_src_b, ext_zero, alu_op, illegal_op};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL cyc%0d ctl_vec: got st=%0d vec=%h expected st=%0d vec=%h",
                         cyc_no, a.st, a, e.st, e);
            end
            cyc_no++;
        end
    end

    function automatic out_t blank(input int st);
        out_t e = '0;
        e.st = 4'(st);
        return e;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle: drive inputs just after the edge, queue what the
    // outputs must look like during this cycle.
    task automatic cyc(input logic rn, input logic [5:0] op, input logic z,
                       input logic j, input logic mr, input out_t e);
        rst_n = rn; opcode = op; zero = z; jr = j; mem_ready = mr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Expand one instruction into its cycle sequence.
    //   fs/ms : wait cycles in instruction fetch / data memory access
    //   zv/jv : zero flag in branch, jr flag in R execute
    //   abort : pull reset during the load's memory read
    task automatic run_instr(input logic [5:0] op, input int fs, input int ms,
                             input logic zv, input logic jv, input bit abort);
        out_t e;
        // instruction fetch, PC+4
        for (int k = 0; k < fs; k++) begin
            e = blank(1); e.mem_read = 1; e.alu_src_b = 2'b01;
            cyc(1, op, rb(), rb(), 1'b0, e);
        end
        e = blank(1); e.mem_read = 1; e.alu_src_b = 2'b01;
        e.ir_write = 1; e.pc_write = 1;
        cyc(1, op, rb(), rb(), 1'b1, e);
        // decode, branch target precompute
        e = blank(2); e.alu_src_b = 2'b11;
        if (!(op inside {RT, LW, SW, BEQ, BNE, ADDI, ORI, JMP})) e.illegal_op = 1;
        cyc(1, op, rb(), rb(), rb(), e);
        if (op == LW || op == SW) begin
            e = blank(3); e.alu_src_a = 1; e.alu_src_b = 2'b10;
            cyc(1, op, rb(), rb(), rb(), e);
            for (int k = 0; k <= ms; k++) begin
                e = blank(op == LW ? 4 : 6); e.iord = 1;
                if (op == LW) e.mem_read = 1; else e.mem_write = 1;
                if (abort && op == LW) begin
                    // async reset lands mid-access: outputs drop at once
                    cyc(1'b0, op, rb(), rb(), 1'b0, blank(0));
                    cyc(1'b1, op, rb(), rb(), rb(), blank(0));
                    return;
                end
                cyc(1, op, rb(), rb(), (k == ms), e);
            end
            if (op == LW) begin
                e = blank(5); e.reg_write = 1; e.mem_to_reg = 1;
                cyc(1, op, rb(), rb(), rb(), e);
            end
        end else if (op == RT) begin
            e = blank(7); e.alu_src_a = 1; e.alu_op = 2'b10;
            if (jv) begin e.pc_write = 1; e.pc_source = 2'b11; end
            cyc(1, op, rb(), jv, rb(), e);
            if (!jv) begin
                e = blank(8); e.reg_write = 1; e.reg_dst = 1;
                cyc(1, op, rb(), rb(), rb(), e);
            end
        end else if (op == BEQ || op == BNE) begin
            e = blank(9); e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_source = 2'b01;
            e.pc_write = (op == BEQ) ? zv : ~zv;
            cyc(1, op, zv, rb(), rb(), e);
        end else if (op == ADDI || op == ORI) begin
            e = blank(10); e.alu_src_a = 1; e.alu_src_b = 2'b10;
            if (op == ORI) begin e.alu_op = 2'b11; e.ext_zero = 1; end
            cyc(1, op, rb(), rb(), rb(), e);
            e = blank(11); e.reg_write = 1;
            cyc(1, op, rb(), rb(), rb(), e);
        end else if (op == JMP) begin
            e = blank(12); e.pc_write = 1; e.pc_source = 2'b10;
            cyc(1, op, rb(), rb(), rb(), e);
        end
    endtask

    initial begin
        logic [5:0] ops [8];
        logic [5:0] op;
        ops = '{RT, LW, SW, BEQ, BNE, ADDI, ORI, JMP};
        rst_n = 1'b0; opcode = '0; zero = 0; jr = 0; mem_ready = 0;
        @(posedge clk); #1;

        // reset held 3 cycles, then release: IDLE, then FETCH
        for (int k = 0; k < 3; k++) cyc(1'b0, 6'h0, rb(), rb(), rb(), blank(0));
        cyc(1'b1, 6'h0, rb(), rb(), rb(), blank(0));

        // directed cases
        run_instr(LW,   0, 0, 0, 0, 0);
        run_instr(SW,   0, 2, 0, 0, 0);
        run_instr(RT,   0, 0, 0, 0, 0);
        run_instr(RT,   0, 0, 0, 1, 0);
        run_instr(BEQ,  0, 0, 1, 0, 0);
        run_instr(BEQ,  0, 0, 0, 0, 0);
        run_instr(BNE,  0, 0, 1, 0, 0);
        run_instr(BNE,  0, 0, 0, 0, 0);
        run_instr(ORI,  1, 0, 0, 0, 0);
        run_instr(ADDI, 0, 0, 0, 0, 0);
        run_instr(JMP,  2, 0, 0, 0, 0);
        run_instr(6'b111111, 0, 0, 0, 0, 0);
        run_instr(LW,   0, 1, 0, 0, 1);
        run_instr(LW,   1, 2, 0, 0, 0);

        // random instruction stream
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do op = 6'($urandom_range(0, 63));
                while (op inside {RT, LW, SW, BEQ, BNE, ADDI, ORI, JMP});
            end else begin
                op = ops[$urandom_range(0, 7)];
            end
            run_instr(op,
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                      rb(), rb(), ($urandom_range(0, 15) == 0));
        end

        // drain scoreboard with a bounded wait
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left, expected 0", exp_q.size());
        end
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
